// File: rtl/cmd_issuer.sv
// cmd_issuer: serializes one GEMM command per accepted request into 32-bit
// words for the command FIFO. The header word goes out first, followed by the
// payload words LSB-first. The block assigns the command ID, fills the length
// field, zeroes the reserved bits, and drops unsupported opcodes.
module cmd_issuer #(
    parameter int cmd_buf_width_gp = 32,
    parameter int payload_width_p  = 128
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        req_v_i,
    output logic                        req_ready_o,
    input  logic [7:0]                  req_op_i,
    input  logic [payload_width_p-1:0]  req_payload_i,
    output logic [7:0]                  next_id_o,
    output logic                        word_v_o,
    output logic [cmd_buf_width_gp-1:0] word_o,
    input  logic                        word_ready_i,
    output logic                        err_op_o,
    output logic                        busy_o
);

    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    localparam logic [payload_width_p-1:0] ALL_ONES = '1;

    state_t                       state_q;
    logic [1:0]                   nwords_q;
    logic [1:0]                   idx_q;
    logic [payload_width_p-1:0]   pay_q;

    logic                         op_ok;
    logic [1:0]                   op_nwords;
    int                           keep_bits;
    logic [payload_width_p-1:0]   keep_mask;
    logic                         accept;
    logic                         xfer;

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign accept      = req_v_i & req_ready_o;
    assign xfer        = word_v_o & word_ready_i;

    // Decode the opcode into its word count and the number of meaningful low payload bits
    always_comb begin
        op_ok     = 1'b1;
        op_nwords = 2'd1;
        keep_bits = 8;
        case (req_op_i)
            8'hF0:        begin op_nwords = 2'd2; keep_bits = 49; end
            8'hF1:        begin op_nwords = 2'd2; keep_bits = 36; end
            8'hF2:        begin op_nwords = 2'd3; keep_bits = 87; end
            8'hF3, 8'hF4: begin op_nwords = 2'd1; keep_bits = 8;  end
            default:      begin op_ok = 1'b0; keep_bits = 0; end
        endcase
        keep_mask = ALL_ONES >> (payload_width_p - keep_bits);
    end

    // Command FSM: latch on accept, then emit the header and the payload words with
    // registered word outputs. The payload is shifted down so that the next word is
    // always in the low slice.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            nwords_q  <= 2'd0;
            idx_q     <= 2'd0;
            pay_q     <= '0;
            next_id_o <= 8'd0;
            word_v_o  <= 1'b0;
            word_o    <= '0;
            err_op_o  <= 1'b0;
        end else begin
            err_op_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (op_ok) begin
                            pay_q     <= req_payload_i & keep_mask;
                            nwords_q  <= op_nwords;
                            word_o    <= {8'h00, 4'h0, op_nwords, 2'b00, next_id_o, req_op_i};
                            word_v_o  <= 1'b1;
                            next_id_o <= next_id_o + 8'd1;
                            state_q   <= HDR;
                        end else begin
                            err_op_o <= 1'b1;
                        end
                    end
                end
                HDR: begin
                    if (xfer) begin
                        word_o  <= pay_q[cmd_buf_width_gp-1:0];
                        pay_q   <= pay_q >> cmd_buf_width_gp;
                        idx_q   <= 2'd0;
                        state_q <= PAY;
                    end
                end
                PAY: begin
                    if (xfer) begin
                        if (idx_q == nwords_q - 2'd1) begin
                            word_v_o <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            word_o <= pay_q[cmd_buf_width_gp-1:0];
                            pay_q  <= pay_q >> cmd_buf_width_gp;
                            idx_q  <= idx_q + 2'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cmd_issuer.md
# cmd_issuer

Command serializer that packs one structured GEMM command per request into the 32-bit word stream consumed by the master controller's command FIFO. It is the transmit end of the command protocol: header word first, then payload words LSB-first. It lives in front of the command FIFO, either on the host-bridge path or in the testbench-side command generator. It assigns command IDs, fills the header length field, zeroes reserved bits, and drops unsupported opcodes.

## Interface
- `cmd_buf_width_gp`, 32: output word width. Fixed by the command FIFO.
- `payload_width_p`, 128: request payload width. Must be ≥ 96.
- `clk_i`  in  1  single clock; all logic rising-edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `req_v_i`  in  1  command request valid.
- `req_ready_o`  out  1  request accepted when `req_v_i & req_ready_o`.
- `req_op_i`  in  8  opcode: F0 fetch, F1 disp, F2 tile, F3 wait_disp, F4 wait_tile.
- `req_payload_i`  in  128  packed command struct, LSB-aligned, sampled at accept.
- `next_id_o`  out  8  ID the next valid command will carry.
- `word_v_o`  out  1  output word valid.
- `word_o`  out  32  output word.
- `word_ready_i`  in  1  FIFO not full; word transfers on `word_v_o & word_ready_i`.
- `err_op_o`  out  1  one-cycle pulse when an unsupported opcode is dropped.
- `busy_o`  out  1  high when state ≠ IDLE.

## Operation
- States: IDLE, HDR, PAY.
- `req_ready_o` = (state == IDLE).
- **IDLE, accept with a valid op:**
  - Latch op, masked payload, and `id = next_id_o`.
  - Set `nwords`: fetch 2, disp 2, tile 3, wait_disp 1, wait_tile 1.
  - Go to HDR. Increment `next_id_o`, mod 256.
- **IDLE, accept with an invalid op:**
  - Pulse `err_op_o` next cycle.
  - Stay in IDLE. `next_id_o` is unchanged. No words are emitted.
- **HDR:** `word_o` = {8'h00, len, id, op}, where `len = 4*nwords` bytes (fetch 8, disp 8, tile 12, wait 4). On handshake, go to PAY with `idx = 0`.
- **PAY:** `word_o` = `payload[32*idx +: 32]`. On handshake:
  - If `idx == nwords-1`, go to IDLE.
  - Otherwise increment `idx`.
- **Reserved-bit masking, applied at latch.** Bits above the struct width are forced to 0:
  - fetch: [127:64] and [63:49]
  - disp: [127:36]
  - tile: [127:87]
  - wait: [127:8]
- Field layout (`fetch_right` at bit 48, tile `dim_b` at [86:79], etc.) is passed through unmodified. The block never reorders fields.
- `word_o` and `word_v_o` are registers. `word_o` stays stable while `word_v_o & ~word_ready_i`.
- **Reset values:**
  - `req_ready_o` = 1 (IDLE)
  - `word_v_o` = 0, `word_o` = 0
  - `next_id_o` = 0
  - `err_op_o` = 0, `busy_o` = 0
- **Reset mid-command:** the partial command is abandoned. The next cycle is IDLE with `word_v_o` = 0. The downstream FIFO must be reset together with this block.

## Timing
- Accept at edge N → header word valid from cycle N+1. `busy_o` = 1 from N+1.
- With `word_ready_i` held high, one word per cycle: a tile command occupies cycles N+1..N+4.
- `req_ready_o` returns to 1 in the cycle after the last payload handshake.
- Back-to-back command period is 1 + 1 + `nwords` cycles (accept cycle + header + payload).
- `err_op_o` pulses in cycle N+1 for an invalid accept at N. The block is ready again at N+1.
- A stall holds state and `idx`. There is no timeout.
- `next_id_o` updates in cycle N+1 after a valid accept.
- ID wrap: the command carrying 255 sets `next_id_o` to 0.

## Test plan
- **Fetch:** op F0, payload `{fetch_right=1, len=16'h0210, start_addr=32'h2000_0040}`, ready held 1 → exactly these words, then `req_ready_o` = 1 one cycle later:
  - `00_08_00_F0`
  - `2000_0040`
  - `0001_0210`
- **Tile with backpressure:** op F2, `dim_b=4, dim_c=4, dim_v=1`, `left_addr=0, right_addr=528`, all other fields 0, reserved bits set to 1 in the stimulus; `word_ready_i` toggles 1,0,0,1… → exactly 4 words, header `00_0C_01_F2`. `word_o` is stable through stalls and word 3 has bits [31:23] = 0.
- **Wait:** op F4, `wait_id=8'h01`, payload [31:8] = FFFFFF → words `00_04_id_F4`, `0000_0001`.
- **Bad op:** op 8'hF7 → `err_op_o` is a single pulse, no `word_v_o`, `next_id_o` unchanged. The following valid fetch uses the old ID.
- **ID wrap:** issue 257 wait_disp commands → headers carry IDs 0..255, then 0. `next_id_o` = 1 at the end.
- **Reset mid-command:** assert `reset_i` during payload word 1 of a tile command → next cycle `word_v_o` = 0, `next_id_o` = 0, `req_ready_o` = 1. A fresh fetch then serializes correctly with ID 0.
